mem_arbiter: RTL and testbench

- Shares the single memory port between two requesters: the core (instruction fetch and data access sequenced by the decoder) and the IO/scan channel (iosc).
- Sequences each access as select → wait-for-ready → complete, with a bounded wait.
- Stalls the core while it is waiting or has lost arbitration.
- Sits between the core controller/bus and the memory macro/IO bridge.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/arb_wait_timer.sv | 31 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default bus widths, the arbiter
// state encoding and a small state-classification helper.
package mem_arbiter_pkg;

  localparam int ARB_DATA_WIDTH = 8;
  localparam int ARB_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_IO   = 2'd2
  } arb_state_t;

  // True while an access owns the memory port.
  function automatic logic arb_in_access(arb_state_t s);
    return (s == ARB_CORE) || (s == ARB_IO);
  endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-state counter for a memory access. Counts cycles spent without a ready
// from the memory and flags the last allowed wait cycle so the owner can abort.
module arb_wait_timer
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] count;

  // Clear has priority over increment; the count saturates so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != CW'(WAIT_MAX))) begin
      count <= count + CW'(1);
    end
  end

  // Expire marks the WAIT_MAX-th wait cycle: a miss here ends the access.
  assign expire = (count == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. The core normally has priority, but after
// STREAK_MAX consecutive core grants with IO waiting, IO is forced in. Each
// access runs select -> wait-for-ready -> complete with a bounded wait.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int STREAK_MAX = 4,
  parameter int WAIT_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic                  o_core_stall,
  output logic                  o_core_rvalid,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  input  logic                  i_io_req,
  input  logic                  i_io_we,
  input  logic [ADDR_WIDTH-1:0] i_io_addr,
  input  logic [DATA_WIDTH-1:0] i_io_wdata,
  output logic                  o_io_done,
  output logic [DATA_WIDTH-1:0] o_io_rdata,
  output logic                  o_mem_cs,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready,
  output logic                  o_err
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic          cooldown;
  logic          in_access;
  logic          wait_expire;
  logic          timer_clr;
  logic          timer_inc;
  logic          io_wins;
  logic          finish;
  logic          abort;

  assign in_access = arb_in_access(state);

  // IO wins if it is alone, or if the core has used up its streak allowance.
  assign io_wins = i_io_req && (!i_core_req || (streak == SW'(STREAK_MAX)));

  // Ready always beats a simultaneous timeout; abort only on a missed last cycle.
  assign finish = in_access && (i_mem_ready || wait_expire);
  assign abort  = in_access && !i_mem_ready && wait_expire;

  // The timer restarts at every grant and at the edge where an access ends.
  assign timer_clr = !in_access || finish;
  assign timer_inc = in_access && !i_mem_ready;

  arb_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .expire(wait_expire)
  );

  // The core is held off until its own access sees ready on the memory port.
  assign o_core_stall = i_core_req && !((state == ARB_CORE) && i_mem_ready);

  // Arbitration and access sequencing. The cycle after any access is a forced
  // idle (cooldown): the finished requester still holds its request while it
  // sees its done/rvalid pulse, so granting then would repeat the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      streak        <= '0;
      cooldown      <= 1'b0;
      o_mem_cs      <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_core_rvalid <= 1'b0;
      o_core_rdata  <= '0;
      o_io_done     <= 1'b0;
      o_io_rdata    <= '0;
      o_err         <= 1'b0;
    end else begin
      o_core_rvalid <= 1'b0;
      o_io_done     <= 1'b0;
      o_err         <= 1'b0;
      cooldown      <= 1'b0;

      case (state)
        ARB_IDLE: begin
          if (!cooldown) begin
            if (io_wins) begin
              state       <= ARB_IO;
              streak      <= '0;
              o_mem_cs    <= 1'b1;
              o_mem_we    <= i_io_we;
              o_mem_addr  <= i_io_addr;
              o_mem_wdata <= i_io_wdata;
            end else if (i_core_req) begin
              state       <= ARB_CORE;
              o_mem_cs    <= 1'b1;
              o_mem_we    <= i_core_we;
              o_mem_addr  <= i_core_addr;
              o_mem_wdata <= i_core_wdata;
              if (!i_io_req) begin
                streak <= '0;
              end else if (streak != SW'(STREAK_MAX)) begin
                streak <= streak + SW'(1);
              end
            end
          end
        end

        ARB_CORE: begin
          if (finish) begin
            state    <= ARB_IDLE;
            cooldown <= 1'b1;
            o_mem_cs <= 1'b0;
            o_err    <= abort;
            if (!o_mem_we) begin
              o_core_rvalid <= 1'b1;
              o_core_rdata  <= abort ? '0 : i_mem_rdata;
            end
          end
        end

        ARB_IO: begin
          if (finish) begin
            state     <= ARB_IDLE;
            cooldown  <= 1'b1;
            o_mem_cs  <= 1'b0;
            o_err     <= abort;
            o_io_done <= 1'b1;
            if (!o_mem_we) begin
              o_io_rdata <= abort ? '0 : i_mem_rdata;
            end
          end
        end

        default: begin
          state    <= ARB_IDLE;
          o_mem_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, single core read, single IO write,
// IO starvation relief, wait timeout, ready on the last wait cycle and reset
// in the middle of an IO access.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_req;
  logic       core_we;
  logic [7:0] core_addr;
  logic [7:0] core_wdata;
  logic       core_stall;
  logic       core_rvalid;
  logic [7:0] core_rdata;
  logic       io_req;
  logic       io_we;
  logic [7:0] io_addr;
  logic [7:0] io_wdata;
  logic       io_done;
  logic [7:0] io_rdata;
  logic       mem_cs;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       err;
  logic       auto_ready;
  logic       manual_ready;

  int compared   = 0;
  int mismatched = 0;

  // The memory model either answers on the first select cycle or follows manual control.
  assign mem_ready = auto_ready ? mem_cs : manual_ready;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .STREAK_MAX(4),
    .WAIT_MAX  (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_core_req   (core_req),
    .i_core_we    (core_we),
    .i_core_addr  (core_addr),
    .i_core_wdata (core_wdata),
    .o_core_stall (core_stall),
    .o_core_rvalid(core_rvalid),
    .o_core_rdata (core_rdata),
    .i_io_req     (io_req),
    .i_io_we      (io_we),
    .i_io_addr    (io_addr),
    .i_io_wdata   (io_wdata),
    .o_io_done    (io_done),
    .o_io_rdata   (io_rdata),
    .o_mem_cs     (mem_cs),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .i_mem_ready  (mem_ready),
    .o_err        (err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    core_req = 1'b1;
    repeat (2) cyc();
    #2;
    compared++; if (mem_cs !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cs: got %b, expected 0", mem_cs); end
    compared++; if (core_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rvalid: got %b, expected 0", core_rvalid); end
    compared++; if (io_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b, expected 0", io_done); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b, expected 0", err); end
    compared++; if (mem_addr !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_addr: got %h, expected 00", mem_addr); end
    compared++; if (core_rdata !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_core_rdata: got %h, expected 00", core_rdata); end
    compared++; if (core_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_stall_hi: got %b, expected 1", core_stall); end
    core_req = 1'b0;
    #1;
    compared++; if (core_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall_lo: got %b, expected 0", core_stall); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_core_read();
    int cs_n = 0, stall_n = 0, rv_n = 0, rv_at = -1;
    logic [7:0] addr_seen = 8'hxx, rd = 8'hxx;
    logic we_seen = 1'bx;
    core_we = 1'b0; core_addr = 8'h10; mem_rdata = 8'hA5; auto_ready = 1'b1;
    core_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) core_req = 1'b0;
      #2;
      if (core_stall) stall_n++;
      if (mem_cs) begin cs_n++; addr_seen = mem_addr; we_seen = mem_we; end
      if (core_rvalid) begin rv_n++; rv_at = i; rd = core_rdata; end
      cyc();
    end
    compared++; if (cs_n !== 1) begin mismatched++; $display("[TB] FAIL core_rd_cs_cycles: got %0d, expected 1", cs_n); end
    compared++; if (addr_seen !== 8'h10) begin mismatched++; $display("[TB] FAIL core_rd_addr: got %h, expected 10", addr_seen); end
    compared++; if (we_seen !== 1'b0) begin mismatched++; $display("[TB] FAIL core_rd_we: got %b, expected 0", we_seen); end
    compared++; if (rv_n !== 1) begin mismatched++; $display("[TB] FAIL core_rd_rvalid_count: got %0d, expected 1", rv_n); end
    compared++; if (rv_at !== 2) begin mismatched++; $display("[TB] FAIL core_rd_latency: got cycle %0d, expected 2", rv_at); end
    compared++; if (rd !== 8'hA5) begin mismatched++; $display("[TB] FAIL core_rd_data: got %h, expected a5", rd); end
    compared++; if (stall_n !== 2) begin mismatched++; $display("[TB] FAIL core_rd_stall_cycles: got %0d, expected 2", stall_n); end
  endtask

  task automatic test_io_write();
    int cs_n = 0, done_n = 0, rv_n = 0, err_n = 0;
    logic [7:0] addr_seen = 8'hxx, wd_seen = 8'hxx;
    logic we_seen = 1'bx;
    io_we = 1'b1; io_addr = 8'h20; io_wdata = 8'h3C; auto_ready = 1'b1;
    io_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) io_req = 1'b0;
      #2;
      if (mem_cs) begin cs_n++; addr_seen = mem_addr; wd_seen = mem_wdata; we_seen = mem_we; end
      if (io_done) done_n++;
      if (core_rvalid) rv_n++;
      if (err) err_n++;
      cyc();
    end
    compared++; if (cs_n !== 1) begin mismatched++; $display("[TB] FAIL io_wr_cs_cycles: got %0d, expected 1", cs_n); end
    compared++; if (we_seen !== 1'b1) begin mismatched++; $display("[TB] FAIL io_wr_we: got %b, expected 1", we_seen); end
    compared++; if (addr_seen !== 8'h20) begin mismatched++; $display("[TB] FAIL io_wr_addr: got %h, expected 20", addr_seen); end
    compared++; if (wd_seen !== 8'h3C) begin mismatched++; $display("[TB] FAIL io_wr_wdata: got %h, expected 3c", wd_seen); end
    compared++; if (done_n !== 1) begin mismatched++; $display("[TB] FAIL io_wr_done_count: got %0d, expected 1", done_n); end
    compared++; if (rv_n !== 0) begin mismatched++; $display("[TB] FAIL io_wr_core_rvalid: got %0d pulses, expected 0", rv_n); end
    compared++; if (err_n !== 0) begin mismatched++; $display("[TB] FAIL io_wr_err: got %0d pulses, expected 0", err_n); end
  endtask

  task automatic test_starvation();
    logic [7:0] exp_g [6] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h10};
    logic [7:0] grants [6];
    int n = 0;
    core_we = 1'b0; core_addr = 8'h10; io_we = 1'b0; io_addr = 8'h20; auto_ready = 1'b1;
    core_req = 1'b1; io_req = 1'b1;
    for (int i = 0; i < 60 && n < 6; i++) begin
      #2;
      if (mem_cs) begin grants[n] = mem_addr; n++; end
      if (io_done) io_req = 1'b0;
      cyc();
    end
    core_req = 1'b0; io_req = 1'b0;
    repeat (4) cyc();
    compared++; if (n !== 6) begin mismatched++; $display("[TB] FAIL starve_grant_count: got %0d, expected 6", n); end
    for (int k = 0; k < n; k++) begin
      compared++;
      if (grants[k] !== exp_g[k]) begin
        mismatched++;
        $display("[TB] FAIL starve_grant_%0d: got addr %h, expected %h", k, grants[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int cs_n = 0, err_n = 0, err_at = -1, rv_n = 0, rv_at = -1;
    logic [7:0] rd = 8'hxx;
    core_we = 1'b0; core_addr = 8'h10; mem_rdata = 8'hA5;
    auto_ready = 1'b0; manual_ready = 1'b0;
    core_req = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (i == 17) core_req = 1'b0;
      #2;
      if (mem_cs) cs_n++;
      if (err) begin err_n++; err_at = i; end
      if (core_rvalid) begin rv_n++; rv_at = i; rd = core_rdata; end
      cyc();
    end
    compared++; if (cs_n !== 15) begin mismatched++; $display("[TB] FAIL timeout_wait_cycles: got %0d, expected 15", cs_n); end
    compared++; if (err_n !== 1) begin mismatched++; $display("[TB] FAIL timeout_err_count: got %0d, expected 1", err_n); end
    compared++; if (err_at !== 16) begin mismatched++; $display("[TB] FAIL timeout_err_cycle: got %0d, expected 16", err_at); end
    compared++; if (rv_at !== 16) begin mismatched++; $display("[TB] FAIL timeout_rvalid_cycle: got %0d, expected 16", rv_at); end
    compared++; if (rv_n !== 1) begin mismatched++; $display("[TB] FAIL timeout_rvalid_count: got %0d, expected 1", rv_n); end
    compared++; if (rd !== 8'h00) begin mismatched++; $display("[TB] FAIL timeout_rdata: got %h, expected 00", rd); end
  endtask

  task automatic test_ready_last();
    int cs_n = 0, err_n = 0, rv_at = -1;
    logic [7:0] rd = 8'hxx;
    logic stall15 = 1'bx;
    core_we = 1'b0; core_addr = 8'h10; mem_rdata = 8'h5A;
    auto_ready = 1'b0; manual_ready = 1'b0;
    core_req = 1'b1;
    for (int i = 0; i < 21; i++) begin
      manual_ready = (i == 15);
      if (i == 17) core_req = 1'b0;
      #2;
      if (mem_cs) cs_n++;
      if (err) err_n++;
      if (i == 15) stall15 = core_stall;
      if (core_rvalid) begin rv_at = i; rd = core_rdata; end
      cyc();
    end
    manual_ready = 1'b0;
    compared++; if (cs_n !== 15) begin mismatched++; $display("[TB] FAIL last_ready_cs_cycles: got %0d, expected 15", cs_n); end
    compared++; if (err_n !== 0) begin mismatched++; $display("[TB] FAIL last_ready_err: got %0d pulses, expected 0", err_n); end
    compared++; if (rv_at !== 16) begin mismatched++; $display("[TB] FAIL last_ready_rvalid_cycle: got %0d, expected 16", rv_at); end
    compared++; if (rd !== 8'h5A) begin mismatched++; $display("[TB] FAIL last_ready_rdata: got %h, expected 5a", rd); end
    compared++; if (stall15 !== 1'b0) begin mismatched++; $display("[TB] FAIL last_ready_stall: got %b, expected 0", stall15); end
  endtask

  task automatic test_reset_mid_io();
    io_we = 1'b0; io_addr = 8'h20; core_we = 1'b0; core_addr = 8'h10; mem_rdata = 8'h5A;
    auto_ready = 1'b0; manual_ready = 1'b0;
    io_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) core_req = 1'b1;
      if (i == 4) begin rst = 1'b1; io_req = 1'b0; end
      if (i == 5) rst = 1'b0;
      if (i == 8) core_req = 1'b0;
      manual_ready = (i == 6);
      #2;
      if (i == 2) begin
        compared++; if (mem_addr !== 8'h20 || mem_cs !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_io_in_access: got cs=%b addr=%h, expected cs=1 addr=20", mem_cs, mem_addr); end
      end
      if (i == 5) begin
        compared++; if (mem_cs !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_io_cs: got %b, expected 0", mem_cs); end
        compared++; if ({io_done, err, core_rvalid} !== 3'b000) begin mismatched++; $display("[TB] FAIL rst_io_pulses: got done/err/rvalid=%b, expected 000", {io_done, err, core_rvalid}); end
        compared++; if (mem_addr !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_io_addr: got %h, expected 00", mem_addr); end
      end
      if (i == 6) begin
        compared++; if (mem_cs !== 1'b1 || mem_addr !== 8'h10) begin mismatched++; $display("[TB] FAIL rst_core_grant: got cs=%b addr=%h, expected cs=1 addr=10", mem_cs, mem_addr); end
        compared++; if ({io_done, err} !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_io_late_pulse: got done/err=%b, expected 00", {io_done, err}); end
      end
      if (i == 7) begin
        compared++; if (core_rvalid !== 1'b1 || core_rdata !== 8'h5A) begin mismatched++; $display("[TB] FAIL rst_core_read: got rvalid=%b data=%h, expected rvalid=1 data=5a", core_rvalid, core_rdata); end
        compared++; if (io_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_io_done_after: got %b, expected 0", io_done); end
      end
      cyc();
    end
    manual_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
    io_req = 1'b0; io_we = 1'b0; io_addr = 8'h00; io_wdata = 8'h00;
    mem_rdata = 8'h00; auto_ready = 1'b0; manual_ready = 1'b0;
    #1;
    $display("[TB] starting mem_arbiter directed tests");
    test_reset();
    test_core_read();
    test_io_write();
    test_starvation();
    test_timeout();
    test_ready_last();
    test_reset_mid_io();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
